irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-triggered interrupt controller with fixed lowest-index
// priority, a single-level IDLE/REQ/SERVICE handshake with the control unit,
// vectored ISR address generation and a saturating lost-event counter.
// Optional feature: define IRQ_MASK_EN to add a per-source mask register
// (ports mask_wr / mask_wdata).
module irq_ctrl #(
  parameter int          NUM_SRC  = 8,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq,
  output logic [3:0]         irq_id,
  input  logic               irq_ack,
  input  logic               irq_status_update,
  input  logic               irq_context,
  output logic               irq_status,
  output logic [31:0]        isr_addr,
  output logic [7:0]         miss_cnt
`ifdef IRQ_MASK_EN
  ,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_wdata
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_irq;
  logic [3:0]         r_irq_id;
  logic               r_irq_status;
  logic [31:0]        r_isr_addr;
  logic [7:0]         r_miss_cnt;
  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_pending;

  logic [NUM_SRC-1:0] w_event;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_eligible;
  logic [3:0]         w_win_id;
  logic               w_ack_req;
  logic               w_lost_any;

  // Lowest set bit index; callers only use the result when the vector is non-zero.
  function automatic logic [3:0] f_first_set(input logic [NUM_SRC-1:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  assign w_event    = irq_src & ~r_src_q;
  assign w_ack_req  = (r_state == S_REQ) && irq_ack;
  // A lost event is one landing on a pending bit that survives this edge;
  // an event coinciding with the acknowledge of its own source re-arms it instead.
  assign w_lost_any = |(w_event & r_pending & ~w_clr);
  assign w_win_id   = f_first_set(w_eligible);

`ifdef IRQ_MASK_EN
  logic [NUM_SRC-1:0] r_mask;

  // Mask register: all sources enabled out of reset.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_mask <= '1;
    end else if (mask_wr) begin
      r_mask <= mask_wdata;
    end else begin
      r_mask <= r_mask;
    end
  end

  assign w_eligible = r_pending & r_mask;
`else
  assign w_eligible = r_pending;
`endif

  // Decode the pending bit cleared by an acknowledge accepted in REQ.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_ack_req && (r_irq_id == 4'(i))) begin
        w_clr[i] = 1'b1;
      end else begin
        w_clr[i] = 1'b0;
      end
    end
  end

  // Edge-detect delay register and pending latch (a new event beats a clear).
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_src_q   <= '0;
      r_pending <= '0;
    end else begin
      r_src_q   <= irq_src;
      r_pending <= (r_pending & ~w_clr) | w_event;
    end
  end

  // Saturating count of edges on which at least one event was lost.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_miss_cnt <= 8'd0;
    end else if (w_lost_any && (r_miss_cnt != 8'hFF)) begin
      r_miss_cnt <= r_miss_cnt + 8'd1;
    end else begin
      r_miss_cnt <= r_miss_cnt;
    end
  end

  // In-ISR flag follows every status strobe regardless of FSM state.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_irq_status <= 1'b0;
    end else if (irq_status_update) begin
      r_irq_status <= irq_context;
    end else begin
      r_irq_status <= r_irq_status;
    end
  end

  // Request handshake FSM with registered irq, irq_id and isr_addr.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state    <= S_IDLE;
      r_irq      <= 1'b0;
      r_irq_id   <= 4'd0;
      r_isr_addr <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((|w_eligible) && !r_irq_status) begin
            r_state  <= S_REQ;
            r_irq    <= 1'b1;
            r_irq_id <= w_win_id;
          end
        end
        S_REQ: begin
          // The latched id is held even if a higher-priority source arrives.
          if (irq_ack) begin
            r_state    <= S_SERVICE;
            r_irq      <= 1'b0;
            r_isr_addr <= VEC_BASE + {26'd0, r_irq_id, 2'b00};
          end
        end
        S_SERVICE: begin
          if (irq_status_update && !irq_context) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign irq        = r_irq;
  assign irq_id     = r_irq_id;
  assign irq_status = r_irq_status;
  assign isr_addr   = r_isr_addr;
  assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (NUM_SRC=8, VEC_BASE=0x100).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_irq_ctrl;

  logic        CLK;
  logic        RES;
  logic [7:0]  irq_src;
  logic        irq;
  logic [3:0]  irq_id;
  logic        irq_ack;
  logic        irq_status_update;
  logic        irq_context;
  logic        irq_status;
  logic [31:0] isr_addr;
  logic [7:0]  miss_cnt;
`ifdef IRQ_MASK_EN
  logic        mask_wr;
  logic [7:0]  mask_wdata;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  irq_ctrl #(.NUM_SRC(8), .VEC_BASE(32'h0000_0100)) dut (
    .CLK(CLK),
    .RES(RES),
    .irq_src(irq_src),
    .irq(irq),
    .irq_id(irq_id),
    .irq_ack(irq_ack),
    .irq_status_update(irq_status_update),
    .irq_context(irq_context),
    .irq_status(irq_status),
    .isr_addr(isr_addr),
    .miss_cnt(miss_cnt)
`ifdef IRQ_MASK_EN
    ,
    .mask_wr(mask_wr),
    .mask_wdata(mask_wdata)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    irq_src = 8'h00;
    irq_ack = 1'b0;
    irq_status_update = 1'b0;
    irq_context = 1'b0;
`ifdef IRQ_MASK_EN
    mask_wr = 1'b0;
    mask_wdata = 8'h00;
`endif
    tick(2);
    RES = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic strobe_status(input logic ctx);
    irq_status_update = 1'b1;
    irq_context = ctx;
    tick(1);
    irq_status_update = 1'b0;
    irq_context = 1'b0;
  endtask

  initial begin
    RES = 1'b1;
    do_reset();

    // Reset values
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    check_val("rst_id", {28'd0, irq_id}, 32'd0);
    check_val("rst_status", {31'd0, irq_status}, 32'd0);
    check_val("rst_isr", isr_addr, 32'd0);
    check_val("rst_miss", {24'd0, miss_cnt}, 32'd0);

    // Single source 2: pending one edge later, irq the edge after
    irq_src = 8'h04;
    tick(1);
    check_val("s2_lat1", {31'd0, irq}, 32'd0);
    tick(1);
    check_val("s2_irq", {31'd0, irq}, 32'd1);
    check_val("s2_id", {28'd0, irq_id}, 32'd2);
    tick(1);
    pulse_ack();
    check_val("s2_isr", isr_addr, 32'h0000_0108);
    check_val("s2_irq_after_ack", {31'd0, irq}, 32'd0);
    strobe_status(1'b0);
    tick(3);
    check_val("s2_pend_cleared", {31'd0, irq}, 32'd0);

    // Sources 4 and 5 together: 4 first, 5 re-raised one edge after MRET
    do_reset();
    irq_src = 8'h30;
    tick(2);
    check_val("s45_id4", {28'd0, irq_id}, 32'd4);
    pulse_ack();
    check_val("s45_isr4", isr_addr, 32'h0000_0110);
    pulse_ack();
    check_val("s45_ack_in_service", isr_addr, 32'h0000_0110);
    strobe_status(1'b0);
    check_val("s45_idle", {31'd0, irq}, 32'd0);
    tick(1);
    check_val("s45_reraise", {31'd0, irq}, 32'd1);
    check_val("s45_id5", {28'd0, irq_id}, 32'd5);

    // Latched id held while a higher-priority source arrives in REQ
    irq_src = 8'h31;
    tick(2);
    check_val("hold_id", {28'd0, irq_id}, 32'd5);

    // Lost events on source 1
    do_reset();
    irq_src = 8'h02;
    tick(1);
    irq_src = 8'h00;
    tick(1);
    check_val("miss_req_id1", {28'd0, irq_id}, 32'd1);
    irq_src = 8'h02;
    tick(1);
    check_val("miss_one", {24'd0, miss_cnt}, 32'd1);
    // Event coinciding with the ack of its own source is not lost and re-arms it
    irq_src = 8'h00;
    tick(1);
    irq_src = 8'h02;
    pulse_ack();
    check_val("miss_ack_coincide", {24'd0, miss_cnt}, 32'd1);
    check_val("miss_isr1", isr_addr, 32'h0000_0104);
    strobe_status(1'b0);
    tick(1);
    check_val("miss_setwins_irq", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      irq_src = 8'h00;
      tick(1);
      irq_src = 8'h02;
      tick(1);
    end
    check_val("miss_sat", {24'd0, miss_cnt}, 32'hFF);

    // Two lost events on the same edge count once
    do_reset();
    irq_src = 8'h03;
    tick(1);
    irq_src = 8'h00;
    tick(1);
    check_val("multi_id0", {28'd0, irq_id}, 32'd0);
    irq_src = 8'h03;
    tick(1);
    check_val("multi_miss", {24'd0, miss_cnt}, 32'd1);

    // In-ISR flag blocks new requests; ack in IDLE is ignored
    do_reset();
    strobe_status(1'b1);
    check_val("ctx_status1", {31'd0, irq_status}, 32'd1);
    irq_src = 8'h01;
    tick(3);
    pulse_ack();
    tick(1);
    check_val("ctx_blocked", {31'd0, irq}, 32'd0);
    check_val("ctx_idle_ack_isr", isr_addr, 32'd0);
    strobe_status(1'b0);
    check_val("ctx_status0", {31'd0, irq_status}, 32'd0);
    check_val("ctx_still_low", {31'd0, irq}, 32'd0);
    tick(1);
    check_val("ctx_raise", {31'd0, irq}, 32'd1);
    check_val("ctx_id0", {28'd0, irq_id}, 32'd0);

    // Asynchronous reset while irq is high, then source held high across reset
    do_reset();
    irq_src = 8'h80;
    tick(2);
    check_val("ares_pre", {31'd0, irq}, 32'd1);
    #2;
    RES = 1'b1;
    #1;
    check_val("ares_irq", {31'd0, irq}, 32'd0);
    check_val("ares_id", {28'd0, irq_id}, 32'd0);
    check_val("ares_isr", isr_addr, 32'd0);
    check_val("ares_miss", {24'd0, miss_cnt}, 32'd0);
    check_val("ares_status", {31'd0, irq_status}, 32'd0);
    tick(1);
    RES = 1'b0;
    tick(1);
    check_val("high_at_rel_lat", {31'd0, irq}, 32'd0);
    tick(1);
    check_val("high_at_rel_irq", {31'd0, irq}, 32'd1);
    check_val("high_at_rel_id", {28'd0, irq_id}, 32'd7);

`ifdef IRQ_MASK_EN
    // Masked source latches pending but does not request
    do_reset();
    mask_wr = 1'b1;
    mask_wdata = 8'hFE;
    tick(1);
    mask_wr = 1'b0;
    irq_src = 8'h01;
    tick(4);
    check_val("mask_blocked", {31'd0, irq}, 32'd0);
    mask_wr = 1'b1;
    mask_wdata = 8'hFF;
    tick(1);
    mask_wr = 1'b0;
    check_val("mask_open_lat", {31'd0, irq}, 32'd0);
    tick(1);
    check_val("mask_open_irq", {31'd0, irq}, 32'd1);
    check_val("mask_open_id", {28'd0, irq_id}, 32'd0);
    mask_wr = 1'b1;
    mask_wdata = 8'h00;
    tick(1);
    mask_wr = 1'b0;
    tick(1);
    check_val("mask_no_withdraw", {31'd0, irq}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
